ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 16 +
 rtl/ccff_word_buf.sv | 87 ++++++++
 rtl/ccff_loader.sv | 162 ++++++++++++++++
 tb/tb_ccff_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state encoding
// and default geometry of the bitstream and its input words.
package ccff_pkg;

    localparam int unsigned BITSTREAM_SIZE_DEF = 29696;
    localparam int unsigned WORD_W_DEF         = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } ccff_state_e;

endpackage

// File: rtl/ccff_word_buf.sv
// Two-deep word buffer feeding the chain serialiser: a shift register that
// hands out bits MSB first, backed by a holding register for bubble-free reload.
import ccff_pkg::*;

module ccff_word_buf #(
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              flush,
    input  logic              accept_en,
    input  logic              pop,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_avail,
    output logic              bit_msb
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  sr_cnt_q, sr_cnt_d;
    logic [WORD_W-1:0] hr_q, hr_d;
    logic              hr_valid_q, hr_valid_d;

    logic shift_now;
    logic sr_empty_next;
    logic accept;

    always_comb begin
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;
        hr_d       = hr_q;
        hr_valid_d = hr_valid_q;

        bit_avail     = (sr_cnt_q != '0);
        bit_msb       = sr_q[WORD_W-1];
        shift_now     = pop && bit_avail;
        sr_empty_next = (sr_cnt_q == '0) || (shift_now && (sr_cnt_q == CNT_W'(1)));
        // The holding register may take a new word in the same cycle it drains.
        in_ready      = accept_en && (!hr_valid_q || sr_empty_next);
        accept        = in_valid && in_ready;

        if (shift_now) begin
            sr_d     = sr_q << 1;
            sr_cnt_d = sr_cnt_q - CNT_W'(1);
        end

        if (sr_empty_next) begin
            if (hr_valid_q) begin
                sr_d       = hr_q;
                sr_cnt_d   = CNT_W'(WORD_W);
                hr_valid_d = accept;
                if (accept) begin
                    hr_d = in_data;
                end
            end else if (accept) begin
                sr_d     = in_data;
                sr_cnt_d = CNT_W'(WORD_W);
            end
        end else if (accept) begin
            hr_d       = in_data;
            hr_valid_d = 1'b1;
        end

        if (flush) begin
            sr_cnt_d   = '0;
            hr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            sr_q       <= '0;
            sr_cnt_q   <= '0;
            hr_q       <= '0;
            hr_valid_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            sr_cnt_q   <= sr_cnt_d;
            hr_q       <= hr_d;
            hr_valid_q <= hr_valid_d;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Streams a bitstream into a configuration flip-flop chain and verifies the
// load by checking that the first bit shifted in has emerged at the chain tail.
import ccff_pkg::*;

module ccff_loader #(
    parameter int unsigned BITSTREAM_SIZE = BITSTREAM_SIZE_DEF,
    parameter int unsigned WORD_W         = WORD_W_DEF
) (
    input  logic                                  prog_clk,
    input  logic                                  prog_reset,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [WORD_W-1:0]                     bs_data,
    input  logic                                  bs_valid,
    output logic                                  bs_ready,
    output logic                                  ccff_head,
    output logic                                  ccff_shift_en,
    input  logic                                  ccff_tail,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [$clog2(BITSTREAM_SIZE+1)-1:0]   bit_count
);

    localparam int unsigned CNT_W = $clog2(BITSTREAM_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BITSTREAM_SIZE - 1);

    ccff_state_e      state_q, state_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             first_bit_q, first_bit_d;
    logic             check_wait_q, check_wait_d;

    logic buf_flush;
    logic buf_accept_en;
    logic buf_pop;
    logic buf_bit_avail;
    logic buf_bit_msb;

    ccff_word_buf #(
        .WORD_W (WORD_W)
    ) u_word_buf (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .flush      (buf_flush),
        .accept_en  (buf_accept_en),
        .pop        (buf_pop),
        .in_data    (bs_data),
        .in_valid   (bs_valid),
        .in_ready   (bs_ready),
        .bit_avail  (buf_bit_avail),
        .bit_msb    (buf_bit_msb)
    );

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        shift_en_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        bit_count_d  = bit_count_q;
        first_bit_d  = first_bit_q;
        check_wait_d = check_wait_q;
        buf_flush    = 1'b0;
        buf_pop      = 1'b0;

        buf_accept_en = (state_q == SHIFT) && !abort
                        && !(buf_bit_avail && (bit_count_q == LAST_IDX));

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d     = SHIFT;
                    bit_count_d = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    buf_flush   = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    buf_flush = 1'b1;
                end else if (buf_bit_avail) begin
                    buf_pop     = 1'b1;
                    head_d      = buf_bit_msb;
                    shift_en_d  = 1'b1;
                    bit_count_d = bit_count_q + CNT_W'(1);
                    if (bit_count_q == '0) begin
                        first_bit_d = buf_bit_msb;
                    end
                    if (bit_count_q == LAST_IDX) begin
                        state_d      = CHECK;
                        check_wait_d = 1'b1;
                        buf_flush    = 1'b1;
                    end
                end
            end
            CHECK: begin
                // First CHECK cycle lets the final bit land in the chain.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (check_wait_q) begin
                    check_wait_d = 1'b0;
                end else begin
                    busy_d = 1'b0;
                    if (ccff_tail == first_bit_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q      <= IDLE;
            head_q       <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            bit_count_q  <= '0;
            first_bit_q  <= 1'b0;
            check_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            bit_count_q  <= bit_count_d;
            first_bit_q  <= first_bit_d;
            check_wait_q <= check_wait_d;
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: 40-bit chain model, two-word loads with randomised
// data and gaps, checked against the expected MSB-first bit stream.
module tb_ccff_loader;

    localparam int BS = 40;
    localparam int WW = 32;
    localparam int CW = $clog2(BS + 1);

    logic          prog_clk = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] bs_data = '0;
    logic          bs_valid = 1'b0;
    logic          bs_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] bit_count;

    logic [BS-1:0] chain;
    logic          force_tail0 = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mon_idx = 0;
    int          mon_bubbles = 0;
    int          mon_hs = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_bits = '0;

    ccff_loader #(
        .BITSTREAM_SIZE (BS),
        .WORD_W         (WW)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .abort         (abort),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (bs_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .bit_count     (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (prog_reset) chain <= '0;
        else if (ccff_shift_en) chain <= {chain[BS-2:0], ccff_head};
    end
    assign ccff_tail = force_tail0 ? 1'b0 : chain[BS-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference stream: bit i of a load is bit (63-i) of {word0, word1}.
    always @(negedge prog_clk) begin
        if (bs_valid && bs_ready) mon_hs++;
        if (mon_en) begin
            if (ccff_shift_en) begin
                if (mon_idx < BS) begin
                    chk("head_bit", ccff_head, exp_bits[63-mon_idx]);
                    chk("bit_count_step", bit_count, mon_idx + 1);
                end else begin
                    chk("shift_past_end", mon_idx, BS - 1);
                end
                mon_idx++;
            end else if (busy && mon_idx > 0 && mon_idx < BS) begin
                mon_bubbles++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge prog_clk); #1;
        start = 1'b1;
        mon_idx = 0;
        mon_bubbles = 0;
        mon_en = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int k;
        bs_data = w;
        bs_valid = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge prog_clk);
            if (bs_ready) break;
        end
        chk("ready_timeout", (k < 100), 1);
        @(posedge prog_clk); #1;
        bs_valid = 1'b0;
    endtask

    task automatic wait_count(input int target);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge prog_clk);
            if (bit_count == CW'(target)) break;
        end
        chk("count_timeout", (k < 200), 1);
    endtask

    task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input int gap, input bit stuck0);
        int  k;
        bit  exp_done;
        exp_bits = {w0, w1};
        force_tail0 = stuck0;
        pulse_start();
        send_word(w0);
        if (gap > 0) begin
            wait_count(WW);
            repeat (gap - 1) @(posedge prog_clk);
            #1;
        end
        send_word(w1);
        for (k = 0; k < 300; k++) begin
            @(negedge prog_clk);
            if (done || error) break;
        end
        chk("finish_timeout", (k < 300), 1);
        exp_done = stuck0 ? !w0[WW-1] : 1'b1;
        chk("total_shifts", mon_idx, BS);
        chk("bubbles", mon_bubbles, gap);
        chk("done", done, exp_done);
        chk("error", error, !exp_done);
        chk("busy_end", busy, 0);
        chk("bit_count_end", bit_count, BS);
        mon_en = 1'b0;
        force_tail0 = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_head"}, ccff_head, 0);
        chk({tag, "_shift_en"}, ccff_shift_en, 0);
        chk({tag, "_ready"}, bs_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_bit_count"}, bit_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        repeat (3) @(posedge prog_clk);
        #1;
        check_idle_outputs("reset");
        prog_reset = 1'b0;

        // Nominal back-to-back load.
        run_load(32'h8000_0001, 32'hA500_0000, 0, 1'b0);

        // A further word after the final bit must not be taken.
        hs0 = mon_hs;
        bs_data = 32'h1234_5678;
        bs_valid = 1'b1;
        repeat (4) begin
            @(negedge prog_clk);
            chk("ready_after_end", bs_ready, 0);
        end
        chk("extra_word_taken", mon_hs - hs0, 0);
        chk("done_held", done, 1);
        chk("count_held", bit_count, BS);
        @(posedge prog_clk); #1;
        bs_valid = 1'b0;

        // Underrun of three cycles before the second word.
        run_load(32'h8000_0001, 32'hA500_0000, 3, 1'b0);

        // Tail stuck at 0 while the first bit is 1.
        run_load(32'hC3C3_0F0F, 32'h5A00_0000, 0, 1'b1);

        // Abort at bit 20, then a clean restart.
        exp_bits = {32'hF0F0_F0F0, 32'h0};
        pulse_start();
        send_word(32'hF0F0_F0F0);
        wait_count(20);
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        mon_en = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_shift_en", ccff_shift_en, 0);
        chk("abort_ready", bs_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        run_load(32'h9876_5432, 32'hFEDC_BA98, 0, 1'b0);

        // Reset in the middle of a load.
        exp_bits = {32'hFFFF_FFFF, 32'h0};
        pulse_start();
        send_word(32'hFFFF_FFFF);
        wait_count(10);
        prog_reset = 1'b1;
        @(posedge prog_clk); #1;
        mon_en = 1'b0;
        check_idle_outputs("midreset");
        prog_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_load($urandom, $urandom, int'($urandom_range(0, 4)),
                     ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
